// File: rtl/bu_rs_pkg.sv
// Shared definitions for the branch-unit reservation station and the branch
// unit it feeds: operation codes, default tag/window widths and the field
// widths of one RS entry.
package bu_rs_pkg;

  localparam int TAG_W_DEF = 6;
  localparam int CW_W_DEF  = 4;
  localparam int OP_W      = 6;
  localparam int DATA_W    = 32;

  // Branch/jump operation codes understood by the EX branch unit.
  typedef enum logic [OP_W-1:0] {
    BR_BEQ  = 6'h00,
    BR_BNE  = 6'h01,
    BR_BLT  = 6'h04,
    BR_BGE  = 6'h05,
    BR_BLTU = 6'h06,
    BR_BGEU = 6'h07,
    BR_JAL  = 6'h08,
    BR_JALR = 6'h09
  } br_op_e;

  // One source operand: ready flag plus its captured value.
  typedef struct packed {
    logic              rdy;
    logic [DATA_W-1:0] val;
  } opnd_t;

endpackage

// File: rtl/bu_rs_pick.sv
// Combinational priority selector: returns the lowest set index of a request
// vector together with a found flag. Shared by the reservation stations.
module bu_rs_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top down so the lowest requesting index is the last write.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bu_rs.sv
// Branch-unit reservation station. A collapsing queue of DEPTH entries (entry 0
// oldest) that snoops two result buses for operands and issues the oldest
// fully-ready entry to the EX branch unit each cycle.
// Optional feature: define BU_RS_WAKEUP_BYPASS_EN to let a same-cycle CDB
// match make an operand ready for select and forward the bus value to EX_*.
module bu_rs
  import bu_rs_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = TAG_W_DEF,
  parameter  int CW_W  = CW_W_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              DP_valid,
  output logic              DP_ready,
  input  logic [OP_W-1:0]   DP_Operation,
  input  logic [DATA_W-1:0] DP_imm,
  input  logic [DATA_W-1:0] DP_PC,
  input  logic [TAG_W-1:0]  DP_Phydst,
  input  logic [CW_W-1:0]   DP_Commit_Window,
  input  logic [TAG_W-1:0]  DP_Src1_tag,
  input  logic [TAG_W-1:0]  DP_Src2_tag,
  input  logic              DP_Src1_rdy,
  input  logic              DP_Src2_rdy,
  input  logic [DATA_W-1:0] DP_Src1_val,
  input  logic [DATA_W-1:0] DP_Src2_val,
  input  logic              CDB0_valid,
  input  logic              CDB1_valid,
  input  logic [TAG_W-1:0]  CDB0_tag,
  input  logic [TAG_W-1:0]  CDB1_tag,
  input  logic [DATA_W-1:0] CDB0_val,
  input  logic [DATA_W-1:0] CDB1_val,
  output logic              EX_en,
  output logic [OP_W-1:0]   EX_Operation,
  output logic [DATA_W-1:0] EX_imm,
  output logic [DATA_W-1:0] EX_PC,
  output logic [DATA_W-1:0] EX_Src1,
  output logic [DATA_W-1:0] EX_Src2,
  output logic [TAG_W-1:0]  EX_Phydst,
  output logic [CW_W-1:0]   EX_Commit_Window,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0]  phydst;
    logic [CW_W-1:0]   cw;
    logic [TAG_W-1:0]  s1_tag;
    logic [TAG_W-1:0]  s2_tag;
    logic              s1_rdy;
    logic              s2_rdy;
    logic [DATA_W-1:0] s1_val;
    logic [DATA_W-1:0] s2_val;
  } entry_t;

  entry_t             q [DEPTH];      // registered entries
  entry_t             w [DEPTH+1];    // entries after this cycle's wakeup; top slot is empty
  entry_t             n [DEPTH];      // next-state entries
  entry_t             dp;             // entry being dispatched, with same-cycle capture
  entry_t             sel;            // entry presented to EX
  logic [DEPTH-1:0]   rdy_vec;
  logic               issue;
  logic [IDX_W-1:0]   pick_idx;
  logic               accept;
  logic [CNT_W-1:0]   wr_idx;
  logic [CNT_W-1:0]   count_nxt;

  // Operand snoop: a not-yet-ready operand picks up a matching broadcast,
  // CDB0 winning when both buses carry the tag.
  function automatic opnd_t snoop(input logic rdy, input logic [TAG_W-1:0] tag,
                                  input logic [DATA_W-1:0] val);
    opnd_t o;
    o.rdy = rdy;
    o.val = val;
    if (!rdy) begin
      if (CDB0_valid && (CDB0_tag == tag)) begin
        o.rdy = 1'b1;
        o.val = CDB0_val;
      end else if (CDB1_valid && (CDB1_tag == tag)) begin
        o.rdy = 1'b1;
        o.val = CDB1_val;
      end
    end
    return o;
  endfunction

  // Wakeup of stored entries and build of the incoming dispatch entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w[i] = q[i];
      if (q[i].valid) begin
        {w[i].s1_rdy, w[i].s1_val} = snoop(q[i].s1_rdy, q[i].s1_tag, q[i].s1_val);
        {w[i].s2_rdy, w[i].s2_val} = snoop(q[i].s2_rdy, q[i].s2_tag, q[i].s2_val);
      end
    end
    w[DEPTH] = '0;

    dp        = '0;
    dp.valid  = 1'b1;
    dp.op     = DP_Operation;
    dp.imm    = DP_imm;
    dp.pc     = DP_PC;
    dp.phydst = DP_Phydst;
    dp.cw     = DP_Commit_Window;
    dp.s1_tag = DP_Src1_tag;
    dp.s2_tag = DP_Src2_tag;
    {dp.s1_rdy, dp.s1_val} = snoop(DP_Src1_rdy, DP_Src1_tag, DP_Src1_val);
    {dp.s2_rdy, dp.s2_val} = snoop(DP_Src2_rdy, DP_Src2_tag, DP_Src2_val);
  end

  // Ready vector for select: stored bits only, or woken bits with bypass.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
`ifdef BU_RS_WAKEUP_BYPASS_EN
      rdy_vec[i] = w[i].valid && w[i].s1_rdy && w[i].s2_rdy;
`else
      rdy_vec[i] = q[i].valid && q[i].s1_rdy && q[i].s2_rdy;
`endif
    end
  end

  bu_rs_pick #(.N(DEPTH)) u_pick (
    .req   (rdy_vec),
    .found (issue),
    .idx   (pick_idx)
  );

  // EX drive: selected entry, data forced to zero when nothing issues.
  always_comb begin
`ifdef BU_RS_WAKEUP_BYPASS_EN
    sel = w[pick_idx];
`else
    sel = q[pick_idx];
`endif
    EX_en            = issue;
    EX_Operation     = issue ? sel.op     : '0;
    EX_imm           = issue ? sel.imm    : '0;
    EX_PC            = issue ? sel.pc     : '0;
    EX_Src1          = issue ? sel.s1_val : '0;
    EX_Src2          = issue ? sel.s2_val : '0;
    EX_Phydst        = issue ? sel.phydst : '0;
    EX_Commit_Window = issue ? sel.cw     : '0;
  end

  // Next queue contents: collapse over the issued slot, then append dispatch.
  always_comb begin
    DP_ready = (count < CNT_W'(DEPTH));
    accept   = DP_valid && DP_ready;
    wr_idx   = issue ? (count - CNT_W'(1)) : count;
    for (int i = 0; i < DEPTH; i++) begin
      n[i] = (issue && (i >= int'(pick_idx))) ? w[i+1] : w[i];
      if (accept && (CNT_W'(i) == wr_idx)) n[i] = dp;
    end
    unique case ({accept, issue})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Queue register; reset and flush both empty the station.
  always_ff @(posedge clk) begin
    // NOTE: state registers take non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst || flush) begin
      // NOTE: payload fields are cleared with the valid/rdy bits; the struct
      // is one register and a uniform clear keeps it that way.
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= n[i];
      count <= count_nxt;
    end
  end

endmodule
